// File: rtl/acc_reg_file_p_if.sv
// Bus between the datapath control and the accumulator register file.
//
// Command semantics: regWrite, LUTSet, regSet, regGet, regSwap and clrReq are
// single-cycle strobes with no ready signal. A strobe is acted on only at a
// rising edge where busy is low. At most one action executes per edge. Any
// strobe that loses priority, or that arrives while busy is high, is dropped
// and never queued. Read data (accData, opRegData) reflects register state
// only, never the commands of the current cycle.
interface acc_reg_file_p_if #(
    parameter int DW = 8,
    parameter int PW = 4
);
    logic          regWrite;
    logic          LUTSet;
    logic          regSet;
    logic          regGet;
    logic          regSwap;
    logic          clrReq;
    logic [DW-1:0] writeData;
    logic [DW-1:0] LUTaddr;
    logic [PW-1:0] opRegAddr;
    logic [DW-1:0] accData;
    logic [DW-1:0] opRegData;
    logic          busy;
    logic          clrDone;
    logic [1:0]    dbg_state;

    modport master (
        output regWrite, LUTSet, regSet, regGet, regSwap, clrReq,
        output writeData, LUTaddr, opRegAddr,
        input  accData, opRegData, busy, clrDone, dbg_state
    );

    modport slave (
        input  regWrite, LUTSet, regSet, regGet, regSwap, clrReq,
        input  writeData, LUTaddr, opRegAddr,
        output accData, opRegData, busy, clrDone, dbg_state
    );
endinterface

// File: rtl/acc_reg_file_p.sv
// Accumulator-centred register file. r0 is the accumulator; it is loaded from
// the ALU or the branch LUT and exchanges data with any general register.
// A small FSM walks the file clearing one register per cycle on request.
module acc_reg_file_p #(
    parameter int DW = 8,
    parameter int PW = 4
) (
    input logic               clk,
    input logic               reset,
    acc_reg_file_p_if.slave   bus
);
    localparam int DEPTH = 2 ** PW;
    localparam logic [PW-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] idx;
    logic [DW-1:0] regs [DEPTH];
    logic          busy_q;
    logic          done_q;

    // Reads come straight from storage: writes become visible the cycle after
    // the edge that performs them, and opRegAddr selects with zero latency.
    assign bus.accData   = regs[0];
    assign bus.opRegData = regs[bus.opRegAddr];
    assign bus.busy      = busy_q;
    assign bus.clrDone   = done_q;
    assign bus.dbg_state = state;

    // Command execution, clear engine and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            state  <= IDLE;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Fixed priority; a winning no-op (address 0) still
                    // swallows every lower-priority strobe of this cycle.
                    if (bus.LUTSet) begin
                        regs[0] <= bus.LUTaddr;
                    end else if (bus.regWrite) begin
                        regs[0] <= bus.writeData;
                    end else if (bus.regSwap) begin
                        if (bus.opRegAddr != '0) begin
                            regs[0]             <= regs[bus.opRegAddr];
                            regs[bus.opRegAddr] <= regs[0];
                        end
                    end else if (bus.regGet) begin
                        if (bus.opRegAddr != '0) begin
                            regs[0] <= regs[bus.opRegAddr];
                        end
                    end else if (bus.regSet) begin
                        if (bus.opRegAddr != '0) begin
                            regs[bus.opRegAddr] <= regs[0];
                        end
                    end else if (bus.clrReq) begin
                        state  <= CLEAR;
                        idx    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    // idx wraps back to 0 after the last register.
                    regs[idx] <= '0;
                    idx       <= idx + PW'(1);
                    if (idx == LAST_IDX) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_acc_reg_file_p.sv
// Self-checking bench for acc_reg_file_p: default (DW=8, PW=4) instance plus
// a DW=16, PW=3 instance. Expected values go into queues when stimulus is
// driven and are popped when the DUT result is sampled.
module tb_acc_reg_file_p;
    logic clk;
    logic reset;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] exp_w_q[$];

    acc_reg_file_p_if #(.DW(8),  .PW(4)) ifa ();
    acc_reg_file_p_if #(.DW(16), .PW(3)) ifb ();

    acc_reg_file_p #(.DW(8), .PW(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    acc_reg_file_p #(.DW(16), .PW(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ifa.regWrite = 0; ifa.LUTSet = 0; ifa.regSet = 0;
        ifa.regGet = 0; ifa.regSwap = 0; ifa.clrReq = 0;
        ifa.writeData = '0; ifa.LUTaddr = '0; ifa.opRegAddr = '0;
        ifb.regWrite = 0; ifb.LUTSet = 0; ifb.regSet = 0;
        ifb.regGet = 0; ifb.regSwap = 0; ifb.clrReq = 0;
        ifb.writeData = '0; ifb.LUTaddr = '0; ifb.opRegAddr = '0;
    endtask

    task automatic cmd_a(input logic wr, input logic lut, input logic set,
                         input logic get, input logic swp, input logic clr,
                         input logic [7:0] wd, input logic [7:0] la,
                         input logic [3:0] n);
        ifa.regWrite = wr; ifa.LUTSet = lut; ifa.regSet = set;
        ifa.regGet = get; ifa.regSwap = swp; ifa.clrReq = clr;
        ifa.writeData = wd; ifa.LUTaddr = la; ifa.opRegAddr = n;
        tick();
        ifa.regWrite = 0; ifa.LUTSet = 0; ifa.regSet = 0;
        ifa.regGet = 0; ifa.regSwap = 0; ifa.clrReq = 0;
    endtask

    task automatic cmd_b(input logic wr, input logic set, input logic swp,
                         input logic clr, input logic [15:0] wd,
                         input logic [2:0] n);
        ifb.regWrite = wr; ifb.regSet = set; ifb.regSwap = swp;
        ifb.clrReq = clr; ifb.writeData = wd; ifb.opRegAddr = n;
        tick();
        ifb.regWrite = 0; ifb.regSet = 0; ifb.regSwap = 0; ifb.clrReq = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_all();
        tick();
        tick();
        checks++;
        if (ifa.accData !== 8'h00) begin
            errors++; $display("FAIL reset_acc: got %h want 00", ifa.accData);
        end
        for (int i = 0; i < 16; i++) begin
            ifa.opRegAddr = 4'(i);
            #1;
            checks++;
            if (ifa.opRegData !== 8'h00) begin
                errors++; $display("FAIL reset_op[%0d]: got %h want 00", i, ifa.opRegData);
            end
        end
        ifa.opRegAddr = '0;
        checks++;
        if (ifa.busy !== 1'b0 || ifa.clrDone !== 1'b0) begin
            errors++; $display("FAIL reset_flags: busy=%b clrDone=%b want 0 0", ifa.busy, ifa.clrDone);
        end
        checks++;
        if (ifb.accData !== 16'h0000 || ifb.busy !== 1'b0) begin
            errors++; $display("FAIL reset_b: acc=%h busy=%b want 0000 0", ifb.accData, ifb.busy);
        end
        reset = 1'b1;
    endtask

    task automatic test_load();
        logic [7:0] e;
        exp_q.push_back(8'h5A);
        cmd_a(1, 0, 0, 0, 0, 0, 8'h5A, 8'h00, 4'd0);
        e = exp_q.pop_front();
        checks++;
        if (ifa.accData !== e) begin
            errors++; $display("FAIL load_write: got %h want %h", ifa.accData, e);
        end
        exp_q.push_back(8'h33);
        cmd_a(1, 1, 0, 0, 0, 0, 8'h77, 8'h33, 4'd0);
        e = exp_q.pop_front();
        checks++;
        if (ifa.accData !== e) begin
            errors++; $display("FAIL load_lut_prio: got %h want %h", ifa.accData, e);
        end
    endtask

    task automatic test_set_get();
        logic [7:0] e;
        cmd_a(1, 0, 0, 0, 0, 0, 8'h5A, 8'h00, 4'd0);
        cmd_a(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 4'd3);
        ifa.opRegAddr = 4'd3;
        #1;
        checks++;
        if (ifa.opRegData !== 8'h5A) begin
            errors++; $display("FAIL set_r3: got %h want 5a", ifa.opRegData);
        end
        cmd_a(1, 0, 0, 0, 0, 0, 8'h11, 8'h00, 4'd0);
        exp_q.push_back(8'h5A);
        cmd_a(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 4'd3);
        e = exp_q.pop_front();
        checks++;
        if (ifa.accData !== e) begin
            errors++; $display("FAIL get_r3: got %h want %h", ifa.accData, e);
        end
        exp_q.push_back(8'h5A);
        cmd_a(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 4'd0);
        e = exp_q.pop_front();
        checks++;
        if (ifa.accData !== e) begin
            errors++; $display("FAIL set_n0: got %h want %h", ifa.accData, e);
        end
        // regWrite beats regSet: r4 must stay at its reset value.
        cmd_a(1, 0, 0, 0, 0, 0, 8'h44, 8'h00, 4'd0);
        exp_q.push_back(8'h99);
        cmd_a(1, 0, 1, 0, 0, 0, 8'h99, 8'h00, 4'd4);
        e = exp_q.pop_front();
        checks++;
        if (ifa.accData !== e) begin
            errors++; $display("FAIL prio_write_acc: got %h want %h", ifa.accData, e);
        end
        ifa.opRegAddr = 4'd4;
        #1;
        checks++;
        if (ifa.opRegData !== 8'h00) begin
            errors++; $display("FAIL prio_set_dropped: got %h want 00", ifa.opRegData);
        end
    endtask

    task automatic test_swap();
        logic [7:0] e;
        cmd_a(1, 0, 0, 0, 0, 0, 8'h3C, 8'h00, 4'd0);
        cmd_a(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 4'd7);
        cmd_a(1, 0, 0, 0, 0, 0, 8'hA1, 8'h00, 4'd0);
        exp_q.push_back(8'h3C);
        cmd_a(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 4'd7);
        e = exp_q.pop_front();
        checks++;
        if (ifa.accData !== e) begin
            errors++; $display("FAIL swap_acc: got %h want %h", ifa.accData, e);
        end
        ifa.opRegAddr = 4'd7;
        #1;
        checks++;
        if (ifa.opRegData !== 8'hA1) begin
            errors++; $display("FAIL swap_r7: got %h want a1", ifa.opRegData);
        end
        exp_q.push_back(8'h3C);
        cmd_a(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 4'd0);
        e = exp_q.pop_front();
        checks++;
        if (ifa.accData !== e) begin
            errors++; $display("FAIL swap_n0: got %h want %h", ifa.accData, e);
        end
    endtask

    task automatic test_clear();
        logic [7:0] e;
        logic [7:0] v;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        for (int i = 15; i >= 1; i--) begin
            cmd_a(1, 0, 0, 0, 0, 0, 8'h10 + 8'(i), 8'h00, 4'd0);
            cmd_a(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 4'(i));
        end
        cmd_a(1, 0, 0, 0, 0, 0, 8'h10, 8'h00, 4'd0);
        ifa.opRegAddr = 4'd9;
        #1;
        checks++;
        if (ifa.opRegData !== 8'h19) begin
            errors++; $display("FAIL fill_r9: got %h want 19", ifa.opRegData);
        end
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
        cmd_a(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 4'd0);
        // Sample j is taken just after clear edge E_j (E0 = clrReq edge).
        for (int j = 0; j < 20; j++) begin
            if (ifa.busy === 1'b1) busy_cnt++;
            if (ifa.clrDone === 1'b1) begin
                done_cnt++;
                done_at = j;
            end
            if (j >= 1 && j <= 16) begin
                ifa.opRegAddr = 4'(j - 1);
                #1;
                e = exp_q.pop_front();
                checks++;
                if (ifa.opRegData !== e) begin
                    errors++; $display("FAIL clr_r%0d: got %h want %h", j - 1, ifa.opRegData, e);
                end
                if (j < 16) begin
                    ifa.opRegAddr = 4'(j);
                    #1;
                    v = 8'h10 + 8'(j);
                    checks++;
                    if (ifa.opRegData !== v) begin
                        errors++; $display("FAIL clr_live_r%0d: got %h want %h", j, ifa.opRegData, v);
                    end
                end
            end
            ifa.regWrite  = (j == 4);
            ifa.writeData = 8'hFF;
            tick();
        end
        ifa.regWrite = 0;
        checks++;
        if (busy_cnt !== 17) begin
            errors++; $display("FAIL clr_busy_cycles: got %0d want 17", busy_cnt);
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 16) begin
            errors++; $display("FAIL clr_done_pulse: count=%0d at=%0d want 1 at 16", done_cnt, done_at);
        end
        checks++;
        if (ifa.accData !== 8'h00) begin
            errors++; $display("FAIL clr_write_ignored: got %h want 00", ifa.accData);
        end
        exp_q.push_back(8'h5A);
        cmd_a(1, 0, 0, 0, 0, 0, 8'h5A, 8'h00, 4'd0);
        e = exp_q.pop_front();
        checks++;
        if (ifa.accData !== e) begin
            errors++; $display("FAIL clr_after_write: got %h want %h", ifa.accData, e);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [7:0] e;
        int done_cnt = 0;
        int busy_cnt = 0;
        for (int i = 5; i <= 9; i++) begin
            cmd_a(1, 0, 0, 0, 0, 0, 8'hC0 + 8'(i), 8'h00, 4'd0);
            cmd_a(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 4'(i));
        end
        cmd_a(1, 0, 0, 0, 0, 0, 8'h77, 8'h00, 4'd0);
        cmd_a(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 4'd0);
        for (int k = 0; k < 5; k++) tick();
        ifa.opRegAddr = 4'd5;
        #1;
        checks++;
        if (ifa.opRegData !== 8'hC5 || ifa.busy !== 1'b1) begin
            errors++; $display("FAIL midclr_pre: r5=%h busy=%b want c5 1", ifa.opRegData, ifa.busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ifa.busy !== 1'b0 || ifa.clrDone !== 1'b0 || ifa.accData !== 8'h00) begin
            errors++; $display("FAIL midclr_reset: busy=%b done=%b acc=%h want 0 0 00",
                               ifa.busy, ifa.clrDone, ifa.accData);
        end
        for (int i = 5; i <= 9; i++) begin
            ifa.opRegAddr = 4'(i);
            #1;
            checks++;
            if (ifa.opRegData !== 8'h00) begin
                errors++; $display("FAIL midclr_r%0d: got %h want 00", i, ifa.opRegData);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (ifa.clrDone === 1'b1) done_cnt++;
        end
        reset = 1'b1;
        exp_q.push_back(8'h22);
        cmd_a(1, 0, 0, 0, 0, 0, 8'h22, 8'h00, 4'd0);
        e = exp_q.pop_front();
        checks++;
        if (ifa.accData !== e) begin
            errors++; $display("FAIL midclr_first_write: got %h want %h", ifa.accData, e);
        end
        for (int k = 0; k < 20; k++) begin
            if (ifa.clrDone === 1'b1) done_cnt++;
            if (ifa.busy === 1'b1) busy_cnt++;
            tick();
        end
        checks++;
        if (done_cnt !== 0 || busy_cnt !== 0) begin
            errors++; $display("FAIL midclr_no_done: done=%0d busy=%0d want 0 0", done_cnt, busy_cnt);
        end
    endtask

    task automatic test_param_sweep();
        logic [15:0] e;
        logic [15:0] v;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        for (int i = 1; i <= 7; i++) begin
            cmd_b(1, 0, 0, 0, 16'h0100 + 16'(i), 3'd0);
            cmd_b(0, 1, 0, 0, 16'h0000, 3'(i));
        end
        for (int i = 1; i <= 7; i++) begin
            ifb.opRegAddr = 3'(i);
            #1;
            v = 16'h0100 + 16'(i);
            checks++;
            if (ifb.opRegData !== v) begin
                errors++; $display("FAIL b_depth_r%0d: got %h want %h", i, ifb.opRegData, v);
            end
        end
        cmd_b(1, 0, 0, 0, 16'h1234, 3'd0);
        cmd_b(0, 1, 0, 0, 16'h0000, 3'd7);
        cmd_b(1, 0, 0, 0, 16'hBEEF, 3'd0);
        exp_w_q.push_back(16'h1234);
        cmd_b(0, 0, 1, 0, 16'h0000, 3'd7);
        e = exp_w_q.pop_front();
        checks++;
        if (ifb.accData !== e) begin
            errors++; $display("FAIL b_swap_acc: got %h want %h", ifb.accData, e);
        end
        ifb.opRegAddr = 3'd7;
        #1;
        checks++;
        if (ifb.opRegData !== 16'hBEEF) begin
            errors++; $display("FAIL b_swap_r7: got %h want beef", ifb.opRegData);
        end
        cmd_b(0, 0, 0, 1, 16'h0000, 3'd0);
        for (int j = 0; j < 14; j++) begin
            if (ifb.busy === 1'b1) busy_cnt++;
            if (ifb.clrDone === 1'b1) begin
                done_cnt++;
                done_at = j;
            end
            tick();
        end
        checks++;
        if (busy_cnt !== 9) begin
            errors++; $display("FAIL b_clr_busy_cycles: got %0d want 9", busy_cnt);
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 8) begin
            errors++; $display("FAIL b_clr_done: count=%0d at=%0d want 1 at 8", done_cnt, done_at);
        end
        checks++;
        if (ifb.accData !== 16'h0000 || ifb.opRegData !== 16'h0000) begin
            errors++; $display("FAIL b_clr_contents: acc=%h r7=%h want 0000 0000", ifb.accData, ifb.opRegData);
        end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_load();
        test_set_get();
        test_swap();
        test_clear();
        test_reset_mid_clear();
        test_param_sweep();
        checks++;
        if (exp_q.size() != 0 || exp_w_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: left %0d/%0d want 0/0", exp_q.size(), exp_w_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
